// File: rtl/mul_pipe.sv
// Two-stage RV32M multiplier: EXE forms four partial products, MEM sums them and
// picks the low or high word, with an optional output register (LATENCY=2).
module mul_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        ex_valid_i,
  input  logic [1:0]  ex_op_i,
  input  logic [31:0] ex_rs1_i,
  input  logic [31:0] ex_rs2_i,
  output logic [31:0] mem_mul_result_o,
  output logic        mem_mul_valid_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  logic               s1_valid_q, s1_valid_d;
  mul_op_e            s1_op_q, s1_op_d;
  logic        [31:0] pp_ll_q, pp_ll_d;
  logic signed [33:0] pp_lh_q, pp_lh_d;
  logic signed [33:0] pp_hl_q, pp_hl_d;
  logic signed [33:0] pp_hh_q, pp_hh_d;

  logic               a_signed, b_signed;
  logic signed [32:0] a_ext, b_ext;
  logic signed [16:0] a_hi, b_hi;
  logic        [15:0] a_lo, b_lo;
  logic               s1_load;
  logic        [63:0] sum;
  logic        [31:0] sel_word;

  // s1 reloads only when MEM is free: an external stall or our own busy holds it.
  assign s1_load = !stall_i && !busy_o;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_signed = (mul_op_e'(ex_op_i) != OP_MULHU);
    b_signed = (mul_op_e'(ex_op_i) == OP_MUL) || (mul_op_e'(ex_op_i) == OP_MULH);
    a_ext    = {a_signed & ex_rs1_i[31], ex_rs1_i};
    b_ext    = {b_signed & ex_rs2_i[31], ex_rs2_i};
    a_hi     = a_ext[32:16];
    b_hi     = b_ext[32:16];
    a_lo     = a_ext[15:0];
    b_lo     = b_ext[15:0];

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    pp_ll_d    = pp_ll_q;
    pp_lh_d    = pp_lh_q;
    pp_hl_d    = pp_hl_q;
    pp_hh_d    = pp_hh_q;

    if (s1_load) begin
      s1_valid_d = ex_valid_i;
      s1_op_d    = mul_op_e'(ex_op_i);
      pp_ll_d    = 32'(a_lo) * 32'(b_lo);
      pp_lh_d    = 34'($signed({1'b0, a_lo})) * 34'(b_hi);
      pp_hl_d    = 34'(a_hi) * 34'($signed({1'b0, b_lo}));
      pp_hh_d    = 34'(a_hi) * 34'(b_hi);
    end
    if (flush_i) s1_valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_MUL;
      pp_ll_q    <= '0;
      pp_lh_q    <= '0;
      pp_hl_q    <= '0;
      pp_hh_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      pp_ll_q    <= pp_ll_d;
      pp_lh_q    <= pp_lh_d;
      pp_hl_q    <= pp_hl_d;
      pp_hh_q    <= pp_hh_d;
    end
  end

  // Bits above 63 of the full 66-bit sum are never selected, so the sum is kept mod 2^64.
  always_comb begin
    sum      = (64'(pp_hh_q) << 32) + ((64'(pp_lh_q) + 64'(pp_hl_q)) << 16) + 64'(pp_ll_q);
    sel_word = (s1_op_q == OP_MUL) ? sum[31:0] : sum[63:32];
  end

  if (LATENCY == 2) begin : g_lat2
    logic [31:0] s2_q, s2_d;
    logic        s2_done_q, s2_done_d;
    logic        s2_load;

    // s2 loads on busy alone, so the stall that busy raises cannot block it.
    assign s2_load = s1_valid_q && !s2_done_q;

    always_comb begin
      s2_d      = s2_q;
      s2_done_d = s2_done_q;
      if (s2_load) begin
        s2_d      = sel_word;
        s2_done_d = 1'b1;
      end
      if (s1_load || flush_i) s2_done_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s2_q      <= '0;
        s2_done_q <= 1'b0;
      end else begin
        s2_q      <= s2_d;
        s2_done_q <= s2_done_d;
      end
    end

    assign busy_o           = s2_load;
    assign mem_mul_valid_o  = s1_valid_q && s2_done_q;
    assign mem_mul_result_o = s2_q;
  end else begin : g_lat1
    assign busy_o           = 1'b0;
    assign mem_mul_valid_o  = s1_valid_q;
    assign mem_mul_result_o = sel_word;
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: a LATENCY=1 and a LATENCY=2 instance, each
// with its own stimulus, checked against 64-bit reference arithmetic.
module tb_mul_pipe;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;

  logic        stall1 = 0, flush1 = 0, v1 = 0;
  logic [1:0]  op1 = 0;
  logic [31:0] a1 = 0, b1 = 0;
  logic [31:0] r1;
  logic        mv1, busy1;

  logic        stall2 = 0, flush2 = 0, v2 = 0;
  logic [1:0]  op2 = 0;
  logic [31:0] a2 = 0, b2 = 0;
  logic [31:0] r2;
  logic        mv2, busy2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  mul_pipe #(.LATENCY(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall1), .flush_i(flush1),
    .ex_valid_i(v1), .ex_op_i(op1), .ex_rs1_i(a1), .ex_rs2_i(b1),
    .mem_mul_result_o(r1), .mem_mul_valid_o(mv1), .busy_o(busy1)
  );

  mul_pipe #(.LATENCY(2)) dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall2), .flush_i(flush2),
    .ex_valid_i(v2), .ex_op_i(op2), .ex_rs1_i(a2), .ex_rs2_i(b2),
    .mem_mul_result_o(r2), .mem_mul_valid_o(mv2), .busy_o(busy2)
  );

  // Full 64-bit product of the extended operands; high or low word by op.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ae, be, p;
    ae = (op != 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
    be = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ae * be;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue1(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    v1 = v; op1 = op; a1 = a; b1 = b;
  endtask

  vec_t tbl[7];
  logic        exp_v;
  logic [31:0] exp_r;

  initial begin
    tbl[0] = '{"mul_neg",     2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1] = '{"mulh_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[2] = '{"mulh_m1x1",   2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    tbl[3] = '{"mulhu_max",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[4] = '{"mulhsu_max",  2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[5] = '{"mulhsu_2x",   2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
    tbl[6] = '{"mul_small",   2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006};

    // Reset state of both instances
    #12;
    check("rst_res1", r1, 32'h0);
    check("rst_val1", {31'b0, mv1}, 32'h0);
    check("rst_busy1", {31'b0, busy1}, 32'h0);
    check("rst_res2", r2, 32'h0);
    check("rst_val2", {31'b0, mv2}, 32'h0);
    check("rst_busy2", {31'b0, busy2}, 32'h0);
    step();
    rst_ni = 1'b1;

    // Reset mid-op: async clear, then the first edge after release accepts
    issue1(1, 2'b00, 32'd9, 32'd9);
    step();
    check("pre_rst_val", {31'b0, mv1}, 32'h1);
    check("pre_rst_res", r1, 32'd81);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_imm_val", {31'b0, mv1}, 32'h0);
    check("rst_imm_res", r1, 32'h0);
    issue1(0, 2'b00, 32'd0, 32'd0);
    step();
    check("rst_hold_val", {31'b0, mv1}, 32'h0);
    rst_ni = 1'b1;
    issue1(1, 2'b00, 32'd2, 32'd3);
    step();
    check("post_rst_val", {31'b0, mv1}, 32'h1);
    check("post_rst_res", r1, 32'h6);

    // Table of directed ops, issued back to back without bubbles
    for (int i = 0; i < 7; i++) begin
      issue1(1, tbl[i].op, tbl[i].a, tbl[i].b);
      step();
      check({tbl[i].name, "_val"}, {31'b0, mv1}, 32'h1);
      check(tbl[i].name, r1, tbl[i].exp);
    end

    // Stall hold: MEM keeps the MUL while a different op waits in EXE
    issue1(1, 2'b00, 32'h0001_0000, 32'h0001_0000);
    step();
    check("stall_pre", r1, 32'h0);
    stall1 = 1'b1;
    issue1(1, 2'b11, 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_res", r1, 32'h0);
      check("stall_val", {31'b0, mv1}, 32'h1);
    end
    stall1 = 1'b0;
    step();
    check("stall_rel_res", r1, 32'h1);
    check("stall_rel_val", {31'b0, mv1}, 32'h1);

    // Flush: A completes in MEM, B flushed from EXE never shows valid
    issue1(1, 2'b00, 32'd3, 32'd4);
    step();
    issue1(1, 2'b00, 32'd5, 32'd6);
    flush1 = 1'b1;
    check("flush_a_val", {31'b0, mv1}, 32'h1);
    check("flush_a_res", r1, 32'd12);
    step();
    flush1 = 1'b0;
    issue1(0, 2'b00, 32'd0, 32'd0);
    check("flush_b_val", {31'b0, mv1}, 32'h0);
    step();
    check("flush_b_val2", {31'b0, mv1}, 32'h0);

    // Randomized LATENCY=1 traffic with stalls and flushes against the model
    exp_v = 1'b0;
    exp_r = '0;
    for (int i = 0; i < 300; i++) begin
      stall1 = ($urandom_range(0, 3) == 0);
      flush1 = ($urandom_range(0, 7) == 0);
      issue1(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom);
      if (i % 5 == 0) a1 = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)};
      if (flush1) exp_v = 1'b0;
      else if (!stall1) begin
        exp_v = v1;
        exp_r = ref_mul(op1, a1, b1);
      end
      step();
      check("rnd1_val", {31'b0, mv1}, {31'b0, exp_v});
      if (exp_v) check("rnd1_res", r1, exp_r);
    end
    stall1 = 1'b0;
    flush1 = 1'b0;
    issue1(0, 2'b00, 32'd0, 32'd0);

    // LATENCY=2: MUL 5*5 then a second op back to back
    v2 = 1; op2 = 2'b00; a2 = 32'd5; b2 = 32'd5;
    step();
    check("l2_c1_busy", {31'b0, busy2}, 32'h1);
    check("l2_c1_val", {31'b0, mv2}, 32'h0);
    op2 = 2'b00; a2 = 32'd7; b2 = 32'd8;
    step();
    check("l2_c2_val", {31'b0, mv2}, 32'h1);
    check("l2_c2_res", r2, 32'h19);
    check("l2_c2_busy", {31'b0, busy2}, 32'h0);
    step();
    v2 = 0;
    check("l2_b2b_busy", {31'b0, busy2}, 32'h1);
    check("l2_b2b_val0", {31'b0, mv2}, 32'h0);
    step();
    check("l2_b2b_val", {31'b0, mv2}, 32'h1);
    check("l2_b2b_res", r2, 32'd56);

    // Randomized LATENCY=2 single ops: busy one cycle, then the final product
    for (int i = 0; i < 60; i++) begin
      v2 = 1; op2 = 2'($urandom_range(0, 3)); a2 = $urandom; b2 = $urandom;
      exp_r = ref_mul(op2, a2, b2);
      step();
      v2 = 0;
      check("rnd2_busy", {31'b0, busy2}, 32'h1);
      step();
      check("rnd2_val", {31'b0, mv2}, 32'h1);
      check("rnd2_res", r2, exp_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
